// File: rtl/div_pkg.sv
// Shared types and sizing for the iterative divider.
package div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign rem_sh = {rem_in, q_in[WIDTH-1]};
    assign ge     = (rem_sh >= {1'b0, divisor});
    // When ge holds the true difference is below divisor, so the low bits are exact.
    assign diff   = rem_sh[WIDTH-1:0] - divisor;

    assign rem_out = ge ? diff : rem_sh[WIDTH-1:0];
    assign q_out   = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/divider.sv
// Multi-cycle restoring divider for DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional DIV_ZERO_DETECT_EN adds an early-exit divide-by-zero path and the div_by_zero flag.
module divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_by_zero
`endif
);

    localparam int unsigned          CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]      LastCnt = CntW'(WIDTH);

    div_state_t       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             dbz_q, dbz_d;
`endif

    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] step_rem, step_q;

    // Magnitudes as unsigned WIDTH bits: |INT_MIN| stays INT_MIN, which is correct unsigned.
    assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .q_in    (q_q),
        .divisor (dvsr_q),
        .rem_out (step_rem),
        .q_out   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvsr_d      = dvsr_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        dbz_d       = dbz_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    q_d     = dividend_mag;
                    dvsr_d  = divisor_mag;
                    neg_q_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_d = is_signed && dividend[WIDTH-1];
`ifdef DIV_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
                    if (divisor == '0) begin
                        state_d     = FIN;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                // Final RUN cycle applies sign correction to the finished magnitudes.
                if (cnt_q == LastCnt) begin
                    state_d     = FIN;
                    quotient_d  = neg_q_q ? -q_q : q_q;
                    remainder_d = neg_r_q ? -rem_q : rem_q;
                end else begin
                    rem_d = step_rem;
                    q_d   = step_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            dvsr_q      <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvsr_q      <= dvsr_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
            dbz_q       <= dbz_d;
`endif
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);
`ifdef DIV_ZERO_DETECT_EN
    assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider; follows DIV_ZERO_DETECT_EN if defined.
module tb_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient, remainder;
    logic        busy, done;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_by_zero;
`endif

    int nchecks = 0;
    int nerrors = 0;

    always #5 clk = ~clk;

    divider #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
`ifdef DIV_ZERO_DETECT_EN
        .div_by_zero (div_by_zero),
`endif
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start is sampled at the posedge between the two negedges (edge N).
    task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges since the caller's reference point until done is seen.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int cyc;
        start_op(s, a, b);
        wait_done(cyc);
        check({tag, " latency"}, 32'(cyc), 32'd33);
        check({tag, " q"}, quotient, eq);
        check({tag, " r"}, remainder, er);
    endtask

    initial begin
        int cyc;
        int ndone;

        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset q", quotient, 32'd0);
        check("reset r", remainder, 32'd0);
        reset = 1'b0;

        run_op("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        check("done busy low", 32'(busy), 32'd0);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);
        check("q held", quotient, 32'd14);

        run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        run_op("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

        // Restart during RUN must be ignored.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("mid busy", 32'(busy), 32'd1);
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc);
        check("mid latency", 32'(cyc + 6), 32'd33);
        check("mid q", quotient, 32'd14);
        check("mid r", remainder, 32'd2);

        // Back-to-back: start while done is high.
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("b2b busy", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b latency", 32'(cyc), 32'd33);
        check("b2b q", quotient, 32'd333);
        check("b2b r", remainder, 32'd1);

        // Reset mid-run abandons the operation.
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst q", quotient, 32'd0);
        check("rst r", remainder, 32'd0);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("rst no done", 32'(ndone), 32'd0);

`ifdef DIV_ZERO_DETECT_EN
        start_op(1'b0, 32'd5, 32'd0);
        wait_done(cyc);
        check("div0 latency", 32'(cyc), 32'd0);
        check("div0 busy", 32'(busy), 32'd0);
        check("div0 q", quotient, 32'hFFFF_FFFF);
        check("div0 r", remainder, 32'd5);
        check("div0 flag", 32'(div_by_zero), 32'd1);
        run_op("after div0", 1'b0, 32'd9, 32'd2, 32'd4, 32'd1);
        check("div0 flag clr", 32'(div_by_zero), 32'd0);
`else
        run_op("divu 5/0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
